// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Trial subtraction is an add of the complemented divisor with carry-in 1; carry-out=1 means no borrow.
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is sampled only while busy==0; done is a one-cycle pulse
    // marking quotient/remainder/div_by_zero as freshly updated, and they hold afterwards.
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

    // One restoring step. diff < divisor whenever carry=1, so its top bit is always zero then.
    always_comb begin
        rs             = {r_q, q_q[WIDTH-1]};
        {carry, diff}  = {1'b0, rs} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH + 1){1'b0}}, 1'b1};
        step_r         = carry ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
        step_q         = {q_q[WIDTH-2:0], carry};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        d_d     = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_RUN;
                    end else begin
                        quo_d  = '1;
                        rem_d  = dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = step_q;
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider at WIDTH=16 with hand-computed results.
module tb_seq_restoring_divider;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total;
    int bad;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // advance one edge and settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges with busy high, bounded; caller has just passed the accept edge.
    task automatic wait_done(input string tag, output int busy_cycles);
        busy_cycles = 0;
        while (busy && busy_cycles < 40) begin
            check({tag, "_nodone_while_busy"}, done, 1'b0);
            tick();
            busy_cycles++;
        end
        check({tag, "_busy_timeout"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r);
        int n;
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1'b1);
        wait_done(tag, n);
        check({tag, "_busy_len"}, n, W);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dbz"}, div_by_zero, 1'b0);
        tick();
        check({tag, "_done_drop"}, done, 1'b0);
        check({tag, "_q_hold"}, quotient, exp_q);
    endtask

    initial begin
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 16'd0);
        check("rst_r", remainder, 16'd0);
        check("rst_dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        tick();

        run_op("t1_100_7", 16'd100, 16'd7, 16'd14, 16'd2);
        run_op("t2_ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0);
        run_op("t2_5_9", 16'd5, 16'd9, 16'd0, 16'd5);
        run_op("t2b_ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0);
        run_op("t2c_ffff_2", 16'hFFFF, 16'd2, 16'h7FFF, 16'd1);
        run_op("t2d_40000_255", 16'd40000, 16'd255, 16'd156, 16'd220);

        // divide by zero: immediate done, busy never rises
        start    = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd0;
        tick();
        start = 1'b0;
        check("t3_busy", busy, 1'b0);
        check("t3_done", done, 1'b1);
        check("t3_q", quotient, 16'hFFFF);
        check("t3_r", remainder, 16'd1234);
        check("t3_dbz", div_by_zero, 1'b1);
        tick();
        check("t3_done_drop", done, 1'b0);
        check("t3_dbz_hold", div_by_zero, 1'b1);
        check("t3_r_hold", remainder, 16'd1234);

        // start during busy is ignored; dbz flag cleared by a normal completion
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd4;
        tick();
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        wait_done("t4", n);
        check("t4_busy_len", n + 5, W);
        check("t4_done", done, 1'b1);
        check("t4_q", quotient, 16'd16);
        check("t4_r", remainder, 16'd2);
        check("t4_dbz", div_by_zero, 1'b0);
        tick();
        check("t4_idle_after", busy, 1'b0);

        // async reset mid-operation
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_q", quotient, 16'd0);
        check("t5_rst_r", remainder, 16'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) n++;
        end
        check("t5_no_done", n, 0);
        rst_n = 1'b1;
        tick();
        run_op("t5_81_9", 16'd81, 16'd9, 16'd9, 16'd0);

        // back-to-back: start held, second op accepted on the done cycle
        start    = 1'b1;
        dividend = 16'd77;
        divisor  = 16'd5;
        tick();
        check("t6a_busy_rise", busy, 1'b1);
        wait_done("t6a", n);
        check("t6a_busy_len", n, W);
        check("t6a_done", done, 1'b1);
        check("t6a_q", quotient, 16'd15);
        check("t6a_r", remainder, 16'd2);
        dividend = 16'd60;
        divisor  = 16'd6;
        tick();
        start = 1'b0;
        check("t6b_accept", busy, 1'b1);
        check("t6b_done_drop", done, 1'b0);
        check("t6b_q_hold", quotient, 16'd15);
        wait_done("t6b", n);
        check("t6b_busy_len", n, W);
        check("t6b_done", done, 1'b1);
        check("t6b_q", quotient, 16'd10);
        check("t6b_r", remainder, 16'd0);

        // randomized invariant spot-check against the bench's own arithmetic
        tick();
        for (int k = 0; k < 60; k++) begin
            a = W'($urandom_range(0, 65535));
            b = W'($urandom_range(1, (k % 2 == 0) ? 255 : 65535));
            run_op("rnd", a, b, a / b, a % b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
